// File: rtl/csr_gpio_pkg.sv
// csr_gpio_pkg: CSR op encodings, register offsets and edge-mode codes for csr_gpio
package csr_gpio_pkg;
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;
  typedef enum logic [1:0] {
    REG_OUT  = 2'd0,
    REG_IN   = 2'd1,
    REG_EN   = 2'd2,
    REG_PEND = 2'd3
  } csr_reg_e;
  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;
  localparam logic [11:0] NUM_REGS = 12'd4;
  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] cur, input logic [31:0] wd);
    return op == OP_WRITE ? wd : op == OP_SET ? cur | wd : op == OP_CLEAR ? cur & ~wd : cur;
  endfunction
endpackage

// File: rtl/csr_gpio_edge_sync.sv
// gpio_edge_sync: two-flop input synchroniser plus delayed copy for edge detection
module gpio_edge_sync
  import csr_gpio_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter logic [1:0] EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);
  localparam logic RISE = (EDGE_MODE & EDGE_RISE) != EDGE_NONE;
  localparam logic FALL = (EDGE_MODE & EDGE_FALL) != EDGE_NONE;
  logic [WIDTH-1:0] s1_q, s2_q, prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= gpio_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign sync_o = s2_q;
  assign edge_o = ({WIDTH{RISE}} & s2_q & ~prev_q) | ({WIDTH{FALL}} & ~s2_q & prev_q);
endmodule

// File: rtl/csr_gpio.sv
// csr_gpio: CSR-mapped GPIO block with OUT/IN/EN/PEND registers and edge-triggered irq
module csr_gpio
  import csr_gpio_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [11:0] BASE_ADDR = 12'h7c1,
  parameter logic [31:0] OUT_RESET = 32'h81,
  parameter logic [1:0]  EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read,
  input  logic [1:0]       modify,
  input  logic [31:0]      wdata,
  input  logic [11:0]      addr,
  output logic [31:0]      rdata,
  output logic             valid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic             irq
);
  logic [11:0]      off;
  logic             hit;
  csr_op_e          op;
  csr_reg_e         sel;
  logic [WIDTH-1:0] w, in_s, edge_s, rsel;
  logic [WIDTH-1:0] out_q, out_d, en_q, en_d, pend_q, pend_d;
  logic [31:0]      rdata_q;
  logic             valid_q, irq_q;
  logic             unused_ok;
  gpio_edge_sync #(.WIDTH(WIDTH), .EDGE_MODE(EDGE_MODE)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .gpio_i(gpio_in),
    .sync_o(in_s),
    .edge_o(edge_s)
  );
  // 12-bit subtraction: an address below BASE_ADDR wraps high and misses
  assign off       = addr - BASE_ADDR;
  assign hit       = off < NUM_REGS;
  assign sel       = csr_reg_e'(off[1:0]);
  assign op        = csr_op_e'(modify);
  assign w         = wdata[WIDTH-1:0];
  assign unused_ok = ^{read, wdata};
  always_comb begin
    rsel   = sel == REG_OUT ? out_q : sel == REG_IN ? in_s : sel == REG_EN ? en_q : pend_q;
    out_d  = hit && sel == REG_OUT ? WIDTH'(csr_apply(op, 32'(out_q), 32'(w))) : out_q;
    en_d   = hit && sel == REG_EN ? WIDTH'(csr_apply(op, 32'(en_q), 32'(w))) : en_q;
    // write and clear both acknowledge; a same-cycle edge still sets the bit
    pend_d = (hit && sel == REG_PEND && op != OP_NONE ?
              (op == OP_SET ? pend_q | w : pend_q & ~w) : pend_q) | edge_s;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= WIDTH'(OUT_RESET);
      en_q    <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      rdata_q <= hit ? 32'(rsel) : '0;
      valid_q <= hit;
      irq_q   <= |(pend_q & en_q);
    end
  end
  assign rdata    = rdata_q;
  assign valid    = valid_q;
  assign gpio_out = out_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_csr_gpio.sv
// tb_csr_gpio: directed vector table, reset-release sequence and randomized run against a reference model
module tb_csr_gpio;
  localparam logic [11:0] B = 12'h7c1;
  logic        clk = 1'b0;
  logic        rst, read, valid, irq;
  logic [1:0]  modify;
  logic [31:0] wdata, rdata;
  logic [11:0] addr;
  logic [7:0]  gpio_in, gpio_out;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  csr_gpio dut (
    .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata), .addr(addr),
    .rdata(rdata), .valid(valid), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  logic [7:0]  m_out, m_en, m_pend;
  logic [7:0]  hist[$];
  logic        m_valid, m_irq;
  logic [31:0] m_rdata;

  function automatic logic [7:0] upd(input logic [1:0] op, input logic [7:0] v, input logic [7:0] w);
    case (op)
      2'd1:    return w;
      2'd2:    return v | w;
      2'd3:    return v & ~w;
      default: return v;
    endcase
  endfunction

  // hist[0] is the pin value sampled at the latest edge; hist[1] is what IN shows
  task automatic model(input logic r, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic [7:0] gi);
    logic [11:0] d;
    logic [7:0]  w, rise;
    logic [7:0]  regs[4];
    if (r) begin
      m_out = 8'h81; m_en = 0; m_pend = 0;
      m_valid = 0; m_rdata = 0; m_irq = 0;
      hist = '{8'h00, 8'h00, 8'h00};
      return;
    end
    d       = a - B;
    w       = wd[7:0];
    regs    = '{m_out, hist[1], m_en, m_pend};
    rise    = hist[1] & ~hist[2];
    m_irq   = |(m_pend & m_en);
    m_valid = d < 12'd4;
    m_rdata = m_valid ? {24'h0, regs[d[1:0]]} : 32'h0;
    if (m_valid && op != 2'd0) begin
      if (d == 12'd0) m_out = upd(op, m_out, w);
      if (d == 12'd2) m_en = upd(op, m_en, w);
      if (d == 12'd3) m_pend = (op == 2'd2) ? (m_pend | w) : (m_pend & ~w);
    end
    m_pend |= rise;
    hist.push_front(gi);
    void'(hist.pop_back());
  endtask

  task automatic cyc(input logic r, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic [7:0] gi);
    rst = r; modify = op; addr = a; wdata = wd; gpio_in = gi; read = (op == 2'd0);
    @(posedge clk);
    model(r, op, a, wd, gi);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  op;
    logic [11:0] a;
    logic [31:0] wd;
    logic [7:0]  gi;
    logic        ev;
    logic [7:0]  erd;
    logic [7:0]  eout;
    logic        ei;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [7:0] g;
    rst = 1; read = 0; modify = 0; wdata = 0; addr = 0; gpio_in = 0;
    hist = '{8'h00, 8'h00, 8'h00};
    // r, op, addr, wdata, gpio_in | valid, rdata, gpio_out, irq
    tbl.push_back(vec_t'{1, 0, 12'h000,   32'h00, 8'h00, 0, 8'h00, 8'h81, 0});
    tbl.push_back(vec_t'{1, 1, B,         32'h00, 8'h00, 0, 8'h00, 8'h81, 0});
    tbl.push_back(vec_t'{0, 0, B + 12'd2, 32'h00, 8'h00, 1, 8'h00, 8'h81, 0});
    tbl.push_back(vec_t'{0, 0, B + 12'd3, 32'h00, 8'h00, 1, 8'h00, 8'h81, 0});
    tbl.push_back(vec_t'{0, 1, B,         32'h0F, 8'h00, 1, 8'h81, 8'h0F, 0});
    tbl.push_back(vec_t'{0, 2, B,         32'hF0, 8'h00, 1, 8'h0F, 8'hFF, 0});
    tbl.push_back(vec_t'{0, 3, B,         32'h3C, 8'h00, 1, 8'hFF, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 0, B,         32'h00, 8'h00, 1, 8'hC3, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 1, B + 12'd4, 32'h55, 8'h00, 0, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 1, B - 12'd1, 32'h55, 8'h00, 0, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 1, B + 12'd1, 32'hFF, 8'h00, 1, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 0, B + 12'd1, 32'h00, 8'h00, 1, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 1, B + 12'd2, 32'h04, 8'h00, 1, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 0, 12'h000,   32'h00, 8'h04, 0, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 0, 12'h000,   32'h00, 8'h04, 0, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 0, 12'h000,   32'h00, 8'h04, 0, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 0, B + 12'd3, 32'h00, 8'h04, 1, 8'h04, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 0, B + 12'd1, 32'h00, 8'h04, 1, 8'h04, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 0, 12'h000,   32'h00, 8'h00, 0, 8'h00, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 0, 12'h000,   32'h00, 8'h00, 0, 8'h00, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 0, 12'h000,   32'h00, 8'h04, 0, 8'h00, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 0, 12'h000,   32'h00, 8'h04, 0, 8'h00, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 3, B + 12'd3, 32'h04, 8'h04, 1, 8'h04, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 0, B + 12'd3, 32'h00, 8'h04, 1, 8'h04, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 3, B + 12'd3, 32'h04, 8'h04, 1, 8'h04, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 0, B + 12'd3, 32'h00, 8'h04, 1, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 2, B + 12'd3, 32'hFF, 8'h04, 1, 8'h00, 8'hC3, 0});
    tbl.push_back(vec_t'{0, 2, B + 12'd2, 32'hFF, 8'h04, 1, 8'h04, 8'hC3, 1});
    tbl.push_back(vec_t'{0, 0, B,         32'h00, 8'h04, 1, 8'hC3, 8'hC3, 1});
    tbl.push_back(vec_t'{1, 1, B,         32'h00, 8'h04, 0, 8'h00, 8'h81, 0});
    tbl.push_back(vec_t'{0, 0, B + 12'd3, 32'h00, 8'h04, 1, 8'h00, 8'h81, 0});
    tbl.push_back(vec_t'{0, 0, B + 12'd2, 32'h00, 8'h04, 1, 8'h00, 8'h81, 0});
    tbl.push_back(vec_t'{0, 0, B + 12'd3, 32'h00, 8'h04, 1, 8'h00, 8'h81, 0});
    tbl.push_back(vec_t'{0, 0, B + 12'd3, 32'h00, 8'h04, 1, 8'h04, 8'h81, 0});
    @(negedge clk);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].gi);
      chk($sformatf("row%0d valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d rdata", i), rdata, 32'(tbl[i].erd));
      chk($sformatf("row%0d gpio_out", i), 32'(gpio_out), 32'(tbl[i].eout));
      chk($sformatf("row%0d irq", i), 32'(irq), 32'(tbl[i].ei));
    end
    // pins already high across reset release: exactly one PEND event, acknowledged at step 3
    cyc(1, 0, 12'h000, 0, 8'hFF);
    cyc(1, 0, 12'h000, 0, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      cyc(0, i == 3 ? 2'd3 : 2'd0, B + 12'd3, 32'hFF, 8'hFF);
      chk($sformatf("release%0d pend", i), rdata, i == 3 ? 32'hFF : 32'h0);
    end
    g = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) g = 8'($urandom);
      cyc($urandom_range(0, 60) == 0, 2'($urandom_range(0, 3)), B - 12'd1 + 12'($urandom_range(0, 6)), $urandom, g);
      chk($sformatf("rand%0d valid", i), 32'(valid), 32'(m_valid));
      chk($sformatf("rand%0d rdata", i), rdata, m_rdata);
      chk($sformatf("rand%0d gpio_out", i), 32'(gpio_out), 32'(m_out));
      chk($sformatf("rand%0d irq", i), 32'(irq), 32'(m_irq));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_gpio.md
CSR_GPIO -- requirements
Module: csr_gpio

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of GPIO channels, legal range 1..32.
REQ-002 SHALL have parameter BASE_ADDR, default 12'h7c1: CSR address of the OUT register.
REQ-003 SHALL have parameter OUT_RESET, default 'h81: OUT value after reset, truncated to WIDTH.
REQ-004 SHALL have parameter EDGE_MODE, default 2'b01: pending trigger; 01 rise, 10 fall, 11 both, 00 none.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port read  input  1  CSR read strobe; ignored for decode, kept for bus uniformity.
REQ-008 SHALL have port modify  input  2  CSR op: 00 none, 01 write, 10 set bits, 11 clear bits.
REQ-009 SHALL have port wdata  input  32  CSR write operand; bits above WIDTH ignored.
REQ-010 SHALL have port addr  input  12  CSR address.
REQ-011 SHALL have port rdata  output  32  registered read data, zero-extended above WIDTH.
REQ-012 SHALL have port valid  output  1  registered address-hit flag.
REQ-013 SHALL have port gpio_in  input  WIDTH  asynchronous input pins.
REQ-014 SHALL have port gpio_out  output  WIDTH  OUT register, driven directly.
REQ-015 SHALL have port irq  output  WIDTH>0 reduced to 1  registered OR of (PEND & EN).

Function
REQ-016 SHALL decode four registers: BASE_ADDR+0 OUT, +1 IN (read-only), +2 EN, +3 PEND.
REQ-017 SHALL, on hit at cycle n, assert valid at n+1 and place the pre-modify register value on rdata at n+1.
REQ-018 SHALL drive valid=0 and rdata=0 in every cycle following a non-hit.
REQ-019 SHALL apply modify to OUT and EN at the hit edge: write=wdata, set=reg|wdata, clear=reg&~wdata.
REQ-020 SHALL ignore all modify ops to IN; a read still returns valid=1.
REQ-021 SHALL treat PEND as: write and clear both clear bits where wdata=1; set ORs wdata into PEND (software-triggered event).
REQ-022 SHALL synchronise gpio_in through two flops (s1, s2); IN reads s2.
REQ-023 SHALL keep a third flop prev=s2 delayed one cycle; edge = per EDGE_MODE from s2 and prev.
REQ-024 SHALL set a PEND bit on the clock edge where its edge term is 1, independent of EN.
REQ-025 SHALL, when an edge and a PEND clear hit the same bit in the same cycle, leave the bit set (edge wins).
REQ-026 SHALL give pin-change-to-PEND latency of exactly 3 clk edges (s1, s2, PEND).
REQ-027 SHALL update irq one cycle after PEND or EN changes.
REQ-028 SHALL not wrap addresses: BASE_ADDR+k computed in 12 bits; hits outside +0..+3 do not occur.

Reset
REQ-029 SHALL, while rst=1 at a clock edge: OUT=OUT_RESET, EN=0, PEND=0, s1=s2=prev=0, valid=0, rdata=0, irq=0.
REQ-030 SHALL give rst priority over any concurrent CSR modify or edge event.
REQ-031 SHALL, after reset release with gpio_in held high and EDGE_MODE rise, set PEND exactly once, 3 cycles after release.

Structure
REQ-032 SHALL take modify encodings, register offsets and EDGE_MODE codes from package csr_gpio_pkg.
REQ-033 SHALL place synchroniser, prev flop and edge logic in one sub-module gpio_edge_sync, parametrised by WIDTH and EDGE_MODE.
REQ-034 SHALL contain no combinational path from addr/modify/wdata to rdata, valid or irq.

Verification
REQ-035 SHALL check reset: after rst, gpio_out=8'h81, read of +2 and +3 returns 0, irq=0.
REQ-036 SHALL check ops on OUT: write 8'h0F, set 8'hF0, clear 8'h3C -> reads return 81, 0F, FF; final gpio_out=8'hC3.
REQ-037 SHALL check edge: gpio_in[2] 0->1 at cycle k -> PEND=8'h04 at k+3; with EN=8'h04 irq=1 at k+4.
REQ-038 SHALL check collision: clear PEND 8'h04 in same cycle as new bit-2 edge -> PEND stays 8'h04.
REQ-039 SHALL check decode: addr=BASE_ADDR+4 with modify write -> valid=0, rdata=0, no register changes; write to IN ignored.
REQ-040 SHALL check mid-operation reset: rst asserted with PEND=8'hFF, irq=1 -> next cycle PEND=0, irq=0, gpio_out=8'h81.
